booth_seq_multiplier: RTL and testbench
=======================================

Name: booth_seq_multiplier

Overview:
Downstream consumer of the keypad operand-capture stage. It waits for the capture stage's validation level, then latches the two signed 8-bit operands and multiplies them with a radix-2 Booth sequential algorithm, one iteration per clock. It delivers a signed 16-bit product with a one-cycle done pulse to the display/BCD stage.

Parameters:
WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
valid_i  input  1  operands-ready level from the capture stage; may stay high for many cycles.
a_i  input  WIDTH  signed multiplicand (two's complement).
b_i  input  WIDTH  signed multiplier (two's complement).
product_o  output  2*WIDTH  signed product of the last completed operation.
done_o  output  1  one-cycle pulse: product_o has just updated.
busy_o  output  1  high from accept until done_o.

Behaviour:
- Reset: asynchronous, active-low, clock clk.
  - On reset: state IDLE; product_o=0, done_o=0, busy_o=0; valid_q (previous valid_i) =0; all datapath registers =0.
  - Reset asserted mid-operation aborts it. No done_o is produced and product_o returns to 0.
- Accept rule: rising edge of valid_i (valid_i=1 and valid_q=0), sampled in IDLE.
  - valid_q updates every cycle in every state.
  - A level held across completion therefore never retriggers.
  - Edges seen while not IDLE are ignored, not queued.
- State machine (IDLE, CALC, DONE):
  - IDLE: on accept, load the following and go to CALC; busy_o<=1.
    - M<=a_i, sign-extended to WIDTH+1 bits.
    - A<=0 (WIDTH+1 bits).
    - Q<=b_i; Qm1<=0; cnt<=WIDTH.
  - CALC, one iteration per clock:
    - On {Q[0],Qm1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no change. All arithmetic is WIDTH+1 bits.
    - Then arithmetic right shift of {A,Q,Qm1} by 1, replicating A's MSB; cnt<=cnt-1.
    - When cnt==1 at the clock edge, the last iteration completes and the FSM goes to DONE.
  - DONE: product_o<={A[WIDTH-1:0],Q}; done_o<=1; busy_o<=0; go to IDLE.
  - IDLE (any cycle not entering DONE): done_o<=0.
- The WIDTH+1-bit accumulator exists so that M=-2^(WIDTH-1) (e.g. -128) negates without overflow. Every full-range operand pair gives the exact product.
- Latency: accept at edge 0; iterations at edges 1..WIDTH; product_o and done_o update at edge WIDTH+1 (edge 9 for WIDTH=8).
  - done_o falls at edge WIDTH+2.
  - The earliest new accept is sampled at edge WIDTH+2.
- product_o holds its value until the next DONE. a_i/b_i are sampled only at accept; later changes have no effect.
- Operand range from the capture stage is ±99. Result range is -9801..9801, but the block is correct for the full WIDTH range.

Decomposition:
- Package mult_pkg: typedef enum mult_state_t {IDLE, CALC, DONE}; localparam MULT_WIDTH=8; localparam PROD_WIDTH=2*MULT_WIDTH.
- Sub-module booth_step (combinational), which is natural to split out:
  - Inputs: A, Q, Qm1, M.
  - Outputs: next {A,Q,Qm1} after add/sub and shift.
  - The top module holds the FSM, counter, edge detect and output registers.

Test Plan:
- a_i=12, b_i=34; valid_i rises -> busy_o high next cycle; product_o=16'h0198 (408) with done_o pulse exactly 9 cycles after the accept edge.
- a_i=-12 (8'hF4), b_i=34 -> product_o=16'hFE68 (-408); a_i=-99, b_i=-99 -> 16'h2649 (9801); a_i=99, b_i=-1 -> 16'hFF9D (-99).
- Boundaries: a_i=-128, b_i=-128 -> 16'h4000 (16384); a_i=0, b_i=-77 -> 16'h0000.
- Held level: valid_i high for 25 cycles -> exactly one done_o pulse. A valid_i low->high pulse during busy_o -> ignored, still one result.
- Operand change: a_i/b_i changed at edge 3 of CALC -> product reflects the originally latched operands.
- rst low at iteration 4 -> immediately product_o=0, busy_o=0, done_o=0. No done_o after release. A fresh valid_i edge gives a correct product.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizes for the sequential Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam int MULT_WIDTH = 8;
  localparam int PROD_WIDTH = 2 * MULT_WIDTH;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of the {A,Q,Qm1} register chain.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], qm1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  // Shift replicates the sign of the (WIDTH+1)-bit accumulator.
  assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier: accepts operands on a rising edge of
// valid_i, iterates once per clock and pulses done_o with the product.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mult_state_t        state_q, state_d;
  logic               valid_q;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     step_a;
  logic [WIDTH-1:0]   step_q;
  logic               step_qm1;
  logic               accept;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (step_a),
    .q_o   (step_q),
    .qm1_o (step_qm1)
  );

  // Only a fresh edge counts, so a level held past completion never retriggers.
  assign accept = (state_q == IDLE) && valid_i && !valid_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          m_d     = {a_i[WIDTH-1], a_i};
          a_d     = '0;
          q_d     = b_i;
          qm1_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        prod_d  = {a_q[WIDTH-1:0], q_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_i;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign product_o = prod_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier against an integer-multiply model.
module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic [15:0] product_o;
  logic        done_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  booth_seq_multiplier #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .product_o (product_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int pr;
    pr = $signed(a) * $signed(b);
    return pr[15:0];
  endfunction

  // Drives one operation from an idle point (just after a posedge) and
  // reports the product, the edge index of done_o relative to the accept
  // edge, and busy_o right after the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output logic busy0);
    bit got;
    int e;
    got   = 0;
    e     = -1;
    p     = 'x;
    busy0 = 1'b0;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    while (!got && e < 40) begin
      @(posedge clk);
      #1;
      e++;
      if (e == 0) begin
        busy0   = busy_o;
        valid_i = 1'b0;
      end
      if (done_o) begin
        got = 1;
        p   = product_o;
      end
    end
    lat = got ? e : -1;
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    valid_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({product_o, done_o, busy_o} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs: got product=%h done=%b busy=%b want 0000/0/0",
               product_o, done_o, busy_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({product_o, done_o, busy_o} !== 18'h0) begin
      bad++;
      $display("FAIL post_reset_idle: got product=%h done=%b busy=%b want 0000/0/0",
               product_o, done_o, busy_o);
    end
    $display("reset: product=%h done=%b busy=%b", product_o, done_o, busy_o);
  endtask

  task automatic test_directed;
    logic [7:0]  ta [6];
    logic [7:0]  tb [6];
    logic [15:0] te [6];
    logic [15:0] p;
    int          lat;
    logic        b0;
    ta = '{8'd12, 8'hF4, 8'd157, 8'd99, 8'h80, 8'd0};
    tb = '{8'd34, 8'd34, 8'd157, 8'hFF, 8'h80, 8'd179};
    te = '{16'h0198, 16'hFE68, 16'h2649, 16'hFF9D, 16'h4000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], p, lat, b0);
      $display("directed: a=%0d b=%0d product=%h latency=%0d",
               $signed(ta[i]), $signed(tb[i]), p, lat);
      total++;
      if (p !== te[i]) begin
        bad++;
        $display("FAIL directed_product[%0d]: got %h want %h", i, p, te[i]);
      end
      total++;
      if (lat != 9) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d want 9", i, lat);
      end
      total++;
      if (b0 !== 1'b1) begin
        bad++;
        $display("FAIL directed_busy[%0d]: got %b want 1", i, b0);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0]  a, b;
    logic [15:0] p, exp;
    int          lat;
    logic        b0;
    for (int i = 0; i < 24; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      exp = ref_mul(a, b);
      run_op(a, b, p, lat, b0);
      $display("random: a=%0d b=%0d product=%h latency=%0d", $signed(a), $signed(b), p, lat);
      total++;
      if (p !== exp || lat != 9) begin
        bad++;
        $display("FAIL random_op[%0d]: got product=%h lat=%0d want %h lat=9", i, p, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p;
    int          lat;
    logic        b0;
    run_op(8'd45, 8'hF6, p, lat, b0);
    // valid_i is already low here, so this new edge is sampled at edge 10.
    a_i     = 8'd7;
    b_i     = 8'd9;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", done_o, busy_o);
    end
    lat = -1;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        lat = e;
        p   = product_o;
      end
    end
    $display("back_to_back: product=%h latency=%0d", p, lat);
    total++;
    if (p !== 16'd63 || lat != 9) begin
      bad++;
      $display("FAIL b2b_second: got product=%h lat=%0d want 003f lat=9", p, lat);
    end
  endtask

  task automatic test_held_level;
    int          pulses;
    logic [15:0] p;
    pulses  = 0;
    p       = 'x;
    a_i     = 8'hE7;
    b_i     = 8'd21;
    valid_i = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        pulses++;
        p = product_o;
      end
    end
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    $display("held_level: pulses=%0d product=%h", pulses, p);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL held_pulses: got %0d want 1", pulses);
    end
    total++;
    if (p !== ref_mul(8'hE7, 8'd21)) begin
      bad++;
      $display("FAIL held_product: got %h want %h", p, ref_mul(8'hE7, 8'd21));
    end
  endtask

  task automatic test_ignored_edge;
    int          pulses;
    logic [15:0] p;
    pulses  = 0;
    p       = 'x;
    a_i     = 8'd88;
    b_i     = 8'd93;
    valid_i = 1'b1;
    for (int e = 0; e < 22; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) valid_i = 1'b0;
      if (e == 3) begin
        valid_i = 1'b1;
        a_i     = 8'd5;
        b_i     = 8'd5;
      end
      if (e == 4) valid_i = 1'b0;
      if (done_o) begin
        pulses++;
        p = product_o;
      end
    end
    $display("ignored_edge: pulses=%0d product=%h", pulses, p);
    total++;
    if (pulses != 1 || p !== ref_mul(8'd88, 8'd93)) begin
      bad++;
      $display("FAIL ignored_edge: got pulses=%0d product=%h want 1 %h",
               pulses, p, ref_mul(8'd88, 8'd93));
    end
  endtask

  task automatic test_operand_change;
    logic [7:0]  a, b;
    logic [15:0] p, exp;
    int          lat;
    a       = 8'($urandom_range(128, 255));
    b       = 8'($urandom_range(1, 127));
    exp     = ref_mul(a, b);
    p       = 'x;
    lat     = -1;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    for (int e = 0; e <= 20 && lat < 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) valid_i = 1'b0;
      if (e == 3) begin
        a_i = ~a;
        b_i = b + 8'd17;
      end
      if (done_o) begin
        lat = e;
        p   = product_o;
      end
    end
    $display("operand_change: a=%0d b=%0d product=%h latency=%0d", $signed(a), $signed(b), p, lat);
    total++;
    if (p !== exp || lat != 9) begin
      bad++;
      $display("FAIL operand_change: got product=%h lat=%0d want %h lat=9", p, lat, exp);
    end
  endtask

  task automatic test_reset_abort;
    logic [15:0] p;
    int          lat;
    int          pulses;
    logic        b0;
    run_op(8'd12, 8'd34, p, lat, b0);
    a_i     = 8'd57;
    b_i     = 8'hFD;
    valid_i = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) valid_i = 1'b0;
    end
    rst = 1'b0;
    #1;
    $display("reset_abort: product=%h done=%b busy=%b", product_o, done_o, busy_o);
    total++;
    if ({product_o, done_o, busy_o} !== 18'h0) begin
      bad++;
      $display("FAIL abort_outputs: got product=%h done=%b busy=%b want 0000/0/0",
               product_o, done_o, busy_o);
    end
    @(posedge clk);
    #1;
    rst    = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done_o) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    run_op(8'hF9, 8'd11, p, lat, b0);
    $display("after_abort: product=%h latency=%0d", p, lat);
    total++;
    if (p !== 16'hFFB3 || lat != 9) begin
      bad++;
      $display("FAIL after_abort: got product=%h lat=%0d want ffb3 lat=9", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_held_level();
    test_ignored_edge();
    test_operand_change();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
